// File: rtl/tetris_pkg.sv
// ============================================================================
//  Module      : tetris_pkg
//  Description : Piece encodings, controller state/event enums and the
//                4x4-box shape offset table shared by the Tetris controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

    localparam logic [2:0] c_PIECE_I = 3'd0;
    localparam logic [2:0] c_PIECE_O = 3'd1;
    localparam logic [2:0] c_PIECE_T = 3'd2;
    localparam logic [2:0] c_PIECE_L = 3'd3;
    localparam logic [2:0] c_PIECE_S = 3'd4;

    typedef enum logic [2:0] {
        ST_SPAWN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_TRY   = 3'd2,
        ST_LOCK  = 3'd3,
        ST_SCAN  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // Bit position of each event in the pending-flag vector; lower wins.
    typedef enum logic [1:0] {
        EV_GRAV  = 2'd0,
        EV_ROT   = 2'd1,
        EV_LEFT  = 2'd2,
        EV_RIGHT = 2'd3
    } event_t;

    // Each entry packs four cells as {dr[1:0], dc[1:0]}, cell 0 in the LSBs.
    localparam logic [15:0] c_SHAPE_TABLE [0:4][0:3] = '{
        '{16'h7654, 16'hEA62, 16'h7654, 16'hEA62},  // I: horizontal / vertical
        '{16'h6521, 16'h6521, 16'h6521, 16'h6521},  // O
        '{16'h5210, 16'h4951, 16'h1654, 16'h6951},  // T
        '{16'h9840, 16'h4210, 16'h9510, 16'h6542},  // L
        '{16'h5421, 16'h9540, 16'h5421, 16'h9540}   // S
    };

    function automatic logic [2:0] map_piece(input logic [2:0] sel);
        return (sel > c_PIECE_S) ? c_PIECE_I : sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_shape_rom.sv
// ============================================================================
//  Module      : tetris_shape_rom
//  Description : Combinational lookup of the four cell offsets of a piece.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_shape_rom
    import tetris_pkg::*;
(
    input  logic [2:0]  i_ptype,
    input  logic [1:0]  i_rot,
    output logic [15:0] o_offsets
);

    always_comb begin
        o_offsets = c_SHAPE_TABLE[0][i_rot];
        if (i_ptype <= c_PIECE_S) begin
            o_offsets = c_SHAPE_TABLE[i_ptype][i_rot];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tetris_game_ctrl.sv
// ============================================================================
//  Module      : tetris_game_ctrl
//  Description : Game sequencer: pending key/gravity events, collision test,
//                lock, line clear, scoring and the registered display map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS      = 20,
    parameter int COLS      = 20,
    parameter int SPAWN_COL = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick_slow,
    input  logic                 tick_fast,
    input  logic                 left,
    input  logic                 right,
    input  logic                 rotate,
    input  logic                 speed,
    input  logic [2:0]           random5,
    output logic [ROWS*COLS-1:0] field,
    output logic [31:0]          score,
    output logic                 game_over
);

    localparam int c_RIW = $clog2(ROWS);
    localparam int c_CIW = $clog2(COLS);

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;
    typedef logic signed [7:0]         pos_t;

    // Box position may be negative (e.g. O piece flush left sits at col -1).
    function automatic grid_t cells_map(input logic [15:0] off, input pos_t row, input pos_t col);
        grid_t g;
        pos_t  r;
        pos_t  c;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            r = row + pos_t'({6'b0, off[4*k+2 +: 2]});
            c = col + pos_t'({6'b0, off[4*k +: 2]});
            if (r >= 0 && r < pos_t'(ROWS) && c >= 0 && c < pos_t'(COLS)) begin
                g[r[c_RIW-1:0]][c[c_CIW-1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic cells_oob(input logic [15:0] off, input pos_t row, input pos_t col);
        logic oob;
        pos_t r;
        pos_t c;
        oob = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r = row + pos_t'({6'b0, off[4*k+2 +: 2]});
            c = col + pos_t'({6'b0, off[4*k +: 2]});
            if (r < 0 || r >= pos_t'(ROWS) || c < 0 || c >= pos_t'(COLS)) begin
                oob = 1'b1;
            end
        end
        return oob;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_key_q;
    logic [3:0]       r_pend;
    logic [2:0]       r_type;
    logic [1:0]       r_rot;
    pos_t             r_row;
    pos_t             r_col;
    logic [1:0]       r_cand_rot;
    pos_t             r_cand_row;
    pos_t             r_cand_col;
    event_t           r_ev;
    grid_t            r_locked;
    grid_t            r_field;
    logic [c_RIW-1:0] r_scan;
    logic [31:0]      r_score;
    logic             r_game_over;

    logic [2:0]       w_spawn_type;
    logic [2:0]       w_cand_type;
    logic [1:0]       w_cand_rot;
    pos_t             w_try_row;
    pos_t             w_try_col;
    logic [15:0]      w_cur_off;
    logic [15:0]      w_cand_off;
    grid_t            w_cur_map;
    grid_t            w_cand_map;
    logic             w_hit;
    logic             w_row_full;
    logic             w_tick;
    logic [3:0]       w_rise;
    logic [3:0]       w_clr;
    logic             w_any_pend;
    event_t           w_sel_ev;

    assign w_spawn_type = map_piece(random5);
    assign w_cand_type  = (r_state == ST_SPAWN) ? w_spawn_type     : r_type;
    assign w_cand_rot   = (r_state == ST_SPAWN) ? 2'd0             : r_cand_rot;
    assign w_try_row    = (r_state == ST_SPAWN) ? pos_t'(0)        : r_cand_row;
    assign w_try_col    = (r_state == ST_SPAWN) ? pos_t'(SPAWN_COL) : r_cand_col;

    tetris_shape_rom u_cur_rom (
        .i_ptype   (r_type),
        .i_rot     (r_rot),
        .o_offsets (w_cur_off)
    );

    tetris_shape_rom u_cand_rom (
        .i_ptype   (w_cand_type),
        .i_rot     (w_cand_rot),
        .o_offsets (w_cand_off)
    );

    assign w_cur_map  = cells_map(w_cur_off, r_row, r_col);
    assign w_cand_map = cells_map(w_cand_off, w_try_row, w_try_col);
    assign w_hit      = cells_oob(w_cand_off, w_try_row, w_try_col) | (|(w_cand_map & r_locked));
    assign w_row_full = &r_locked[r_scan];

    assign w_tick     = speed ? tick_fast : tick_slow;
    assign w_rise     = {right & ~r_key_q[2], left & ~r_key_q[1], rotate & ~r_key_q[0], w_tick};
    assign w_any_pend = |r_pend;

    always_comb begin
        w_sel_ev = EV_RIGHT;
        if (r_pend[EV_GRAV]) begin
            w_sel_ev = EV_GRAV;
        end else if (r_pend[EV_ROT]) begin
            w_sel_ev = EV_ROT;
        end else if (r_pend[EV_LEFT]) begin
            w_sel_ev = EV_LEFT;
        end
    end

    // A new rise in the same cycle as a clear re-arms the flag, so no event is lost.
    always_comb begin
        w_clr = '0;
        if (r_state == ST_IDLE && w_any_pend) begin
            w_clr[w_sel_ev] = 1'b1;
        end
        if (r_state == ST_SCAN && w_state_next == ST_SPAWN) begin
            w_clr[3:1] = 3'b111;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SPAWN: w_state_next = w_hit ? ST_OVER : ST_IDLE;
            ST_IDLE:  if (w_any_pend) w_state_next = ST_TRY;
            ST_TRY:   w_state_next = (w_hit && r_ev == EV_GRAV) ? ST_LOCK : ST_IDLE;
            ST_LOCK:  w_state_next = ST_SCAN;
            ST_SCAN:  if (!w_row_full && r_scan == '0) w_state_next = ST_SPAWN;
            ST_OVER:  w_state_next = ST_OVER;
            default:  w_state_next = ST_SPAWN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_SPAWN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_q     <= '0;
            r_pend      <= '0;
            r_type      <= c_PIECE_I;
            r_rot       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_cand_rot  <= '0;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_ev        <= EV_GRAV;
            r_locked    <= '0;
            r_field     <= '0;
            r_scan      <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_key_q <= {right, left, rotate};
            if (r_state != ST_OVER) begin
                r_pend <= (r_pend & ~w_clr) | w_rise;

                if (r_state == ST_TRY && !w_hit) begin
                    r_field <= r_locked | w_cand_map;
                end else if (r_state == ST_IDLE || r_state == ST_TRY) begin
                    r_field <= r_locked | w_cur_map;
                end else begin
                    r_field <= r_locked;
                end

                case (r_state)
                    ST_SPAWN: begin
                        r_type <= w_spawn_type;
                        r_rot  <= '0;
                        r_row  <= '0;
                        r_col  <= pos_t'(SPAWN_COL);
                        if (w_hit) begin
                            r_game_over <= 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (w_any_pend) begin
                            r_ev       <= w_sel_ev;
                            r_cand_rot <= (w_sel_ev == EV_ROT)   ? r_rot + 2'd1      : r_rot;
                            r_cand_row <= (w_sel_ev == EV_GRAV)  ? r_row + pos_t'(1) : r_row;
                            r_cand_col <= (w_sel_ev == EV_LEFT)  ? r_col - pos_t'(1) :
                                          (w_sel_ev == EV_RIGHT) ? r_col + pos_t'(1) : r_col;
                        end
                    end
                    ST_TRY: begin
                        if (!w_hit) begin
                            r_rot <= r_cand_rot;
                            r_row <= r_cand_row;
                            r_col <= r_cand_col;
                        end
                    end
                    ST_LOCK: begin
                        r_locked <= r_locked | w_cur_map;
                        r_scan   <= c_RIW'(ROWS - 1);
                    end
                    ST_SCAN: begin
                        if (w_row_full) begin
                            // Everything above the cleared row drops one; the same row is re-checked.
                            for (int i = ROWS - 1; i > 0; i--) begin
                                if (c_RIW'(i) <= r_scan) begin
                                    r_locked[i] <= r_locked[i-1];
                                end
                            end
                            r_locked[0] <= '0;
                            r_score     <= r_score + 32'd1;
                        end else if (r_scan != '0) begin
                            r_scan <= r_scan - c_RIW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign field     = r_field;
    assign score     = r_score;
    assign game_over = r_game_over;

endmodule

`default_nettype wire
